// File: rtl/sim_controller.sv
// Turns UI clicks/speed/seed selections into STEP/TOGGLE/SEED commands for the board engine.
// Latency: pending flag registered, command valid one cycle later; holds the command while cmd_ready_in is low.
module sim_controller #(
    parameter int LOG_BOARD_SIZE = 9,
    parameter int LOG_MAX_SPEED  = 4,
    parameter int LOG_NUM_SEED   = 2,
    parameter int GEN_WIDTH      = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      frame_start_in,
    input  logic                      click_in,
    input  logic [LOG_MAX_SPEED-1:0]  speed_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic [LOG_NUM_SEED-1:0]   seed_idx_in,
    input  logic                      seed_en_in,
    output logic                      cmd_valid_out,
    output logic [1:0]                cmd_op_out,
    output logic [LOG_BOARD_SIZE-1:0] cmd_x_out,
    output logic [LOG_BOARD_SIZE-1:0] cmd_y_out,
    output logic [LOG_NUM_SEED-1:0]   cmd_seed_out,
    input  logic                      cmd_ready_in,
    output logic [GEN_WIDTH-1:0]      generation_out,
    output logic                      paused_out
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_SEED   = 2'b11;
    localparam int CW = LOG_MAX_SPEED + 1;
    localparam logic [CW-1:0] FULL = CW'(1 << LOG_MAX_SPEED);

    state_t                    state_q, state_d;
    logic                      cmd_valid_q, cmd_valid_d;
    logic [1:0]                cmd_op_q, cmd_op_d;
    logic [LOG_BOARD_SIZE-1:0] cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
    logic [LOG_NUM_SEED-1:0]   cmd_seed_q, cmd_seed_d;
    logic [GEN_WIDTH-1:0]      gen_q, gen_d;
    logic                      paused_q;
    logic [LOG_MAX_SPEED-1:0]  frame_cnt_q, frame_cnt_d;
    logic                      step_pend_q, step_pend_d;
    logic                      toggle_pend_q, toggle_pend_d;
    logic [LOG_BOARD_SIZE-1:0] tog_x_q, tog_x_d, tog_y_q, tog_y_d;
    logic                      seed_pend_q, seed_pend_d;
    logic                      seed_rearm_q, seed_rearm_d;
    logic [LOG_NUM_SEED-1:0]   seed_pidx_q, seed_pidx_d;
    logic                      seed_en_prev_q;
    logic [LOG_NUM_SEED-1:0]   seed_idx_prev_q;

    logic            paused_now, step_set, seed_trig, handshake;
    logic [CW-1:0]   period, cnt_inc;

    assign paused_now = (speed_in == '0) || seed_en_in;
    assign period     = FULL - {1'b0, speed_in};
    assign cnt_inc    = {1'b0, frame_cnt_q} + CW'(1);
    assign step_set   = frame_start_in && !paused_now && (cnt_inc >= period);
    assign seed_trig  = seed_en_in && (!seed_en_prev_q || (seed_idx_in != seed_idx_prev_q));
    assign handshake  = cmd_valid_q && cmd_ready_in;

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_x_d       = cmd_x_q;
        cmd_y_d       = cmd_y_q;
        cmd_seed_d    = cmd_seed_q;
        gen_d         = gen_q;
        frame_cnt_d   = frame_cnt_q;
        step_pend_d   = step_pend_q;
        toggle_pend_d = toggle_pend_q;
        tog_x_d       = tog_x_q;
        tog_y_d       = tog_y_q;
        seed_pend_d   = seed_pend_q;
        seed_rearm_d  = seed_rearm_q;
        seed_pidx_d   = seed_pidx_q;

        if (frame_start_in && !paused_now) begin
            frame_cnt_d = step_set ? '0 : cnt_inc[LOG_MAX_SPEED-1:0];
        end

        if (handshake && cmd_op_q == OP_STEP) step_pend_d = 1'b0;
        if (step_set) step_pend_d = 1'b1;

        if (handshake && cmd_op_q == OP_TOGGLE) toggle_pend_d = 1'b0;
        if (click_in && !seed_en_in && !toggle_pend_q) begin
            toggle_pend_d = 1'b1;
            tog_x_d       = cursor_x_in;
            tog_y_d       = cursor_y_in;
        end

        // A trigger that misses the captured SEED payload must survive its acceptance.
        if (handshake && cmd_op_q == OP_SEED) begin
            seed_pend_d  = seed_rearm_q;
            seed_rearm_d = 1'b0;
        end
        if (seed_trig) begin
            seed_pend_d = 1'b1;
            seed_pidx_d = seed_idx_in;
            if ((state_q == S_IDLE && seed_pend_q) ||
                (state_q == S_ISSUE && cmd_op_q == OP_SEED && !handshake)) begin
                seed_rearm_d = 1'b1;
            end
        end

        if (handshake) begin
            if (cmd_op_q == OP_STEP) gen_d = gen_q + GEN_WIDTH'(1);
            if (cmd_op_q == OP_SEED) gen_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (seed_pend_q || toggle_pend_q || step_pend_q) begin
                    state_d     = S_ISSUE;
                    cmd_valid_d = 1'b1;
                    if (seed_pend_q) begin
                        cmd_op_d   = OP_SEED;
                        cmd_seed_d = seed_pidx_q;
                    end else if (toggle_pend_q) begin
                        cmd_op_d = OP_TOGGLE;
                        cmd_x_d  = tog_x_q;
                        cmd_y_d  = tog_y_q;
                    end else begin
                        cmd_op_d = OP_STEP;
                    end
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    state_d     = S_IDLE;
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= S_IDLE;
            cmd_valid_q     <= 1'b0;
            cmd_op_q        <= OP_NONE;
            cmd_x_q         <= '0;
            cmd_y_q         <= '0;
            cmd_seed_q      <= '0;
            gen_q           <= '0;
            paused_q        <= 1'b0;
            frame_cnt_q     <= '0;
            step_pend_q     <= 1'b0;
            toggle_pend_q   <= 1'b0;
            tog_x_q         <= '0;
            tog_y_q         <= '0;
            seed_pend_q     <= 1'b0;
            seed_rearm_q    <= 1'b0;
            seed_pidx_q     <= '0;
            seed_en_prev_q  <= 1'b0;
            seed_idx_prev_q <= '0;
        end else begin
            state_q         <= state_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_op_q        <= cmd_op_d;
            cmd_x_q         <= cmd_x_d;
            cmd_y_q         <= cmd_y_d;
            cmd_seed_q      <= cmd_seed_d;
            gen_q           <= gen_d;
            paused_q        <= paused_now;
            frame_cnt_q     <= frame_cnt_d;
            step_pend_q     <= step_pend_d;
            toggle_pend_q   <= toggle_pend_d;
            tog_x_q         <= tog_x_d;
            tog_y_q         <= tog_y_d;
            seed_pend_q     <= seed_pend_d;
            seed_rearm_q    <= seed_rearm_d;
            seed_pidx_q     <= seed_pidx_d;
            seed_en_prev_q  <= seed_en_in;
            seed_idx_prev_q <= seed_idx_in;
        end
    end

    assign cmd_valid_out  = cmd_valid_q;
    assign cmd_op_out     = cmd_op_q;
    assign cmd_x_out      = cmd_x_q;
    assign cmd_y_out      = cmd_y_q;
    assign cmd_seed_out   = cmd_seed_q;
    assign generation_out = gen_q;
    assign paused_out     = paused_q;
endmodule

// File: doc/sim_controller.md
Name: sim_controller

Overview:
- Sits directly downstream of the user-interface stage. Consumes its click, cursor, speed and seed selections, and turns them into commands for the board update engine.
- Three command types: advance one generation (STEP), flip the cell under the cursor (TOGGLE), and load a seed pattern (SEED).
- Commands go out one at a time over a single valid/ready interface, arbitrated by a small FSM. STEP is paced in frames by a speed-controlled frame counter.

Parameters:
LOG_BOARD_SIZE, 9, width of cursor/cell coordinates
LOG_MAX_SPEED, 4, width of speed_in; frame period derives from it
LOG_NUM_SEED, 2, width of seed index
GEN_WIDTH, 16, width of generation counter

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset; asynchronous assert, active-low
frame_start_in  in  1  one-cycle pulse at start of each video frame
click_in  in  1  one-cycle click pulse from user interface
speed_in  in  LOG_MAX_SPEED  0 = paused, larger = faster
cursor_x_in  in  LOG_BOARD_SIZE  cursor column
cursor_y_in  in  LOG_BOARD_SIZE  cursor row
seed_idx_in  in  LOG_NUM_SEED  selected seed
seed_en_in  in  1  seed mode switch (level)
cmd_valid_out  out  1  command valid
cmd_op_out  out  2  01 STEP, 10 TOGGLE, 11 SEED, 00 none
cmd_x_out  out  LOG_BOARD_SIZE  TOGGLE column
cmd_y_out  out  LOG_BOARD_SIZE  TOGGLE row
cmd_seed_out  out  LOG_NUM_SEED  SEED index
cmd_ready_in  in  1  engine accepts command
generation_out  out  GEN_WIDTH  accepted STEPs since last SEED
paused_out  out  1  stepping inhibited

Behaviour:
- Reset (rst_n_in low, async):
  - All outputs 0, frame counter 0, all pending flags 0, FSM in IDLE.
  - Reset mid-handshake drops the command; no pulse leaks after release.
- paused_out: registered; equals (speed_in == 0) || seed_en_in, one cycle late.
- Frame counter (LOG_MAX_SPEED bits), period P = 2^LOG_MAX_SPEED - speed_in:
  - While paused: holds its value; no STEP is generated.
  - Otherwise, on frame_start_in: if counter + 1 >= P, set step_pend and clear the counter; else increment.
  - A speed increase that leaves counter >= P yields a STEP on the next frame_start_in.
  - speed_in = 2^LOG_MAX_SPEED - 1 gives P = 1, i.e. a STEP every frame.
- step_pend:
  - Coalesces: a new STEP while step_pend is set is merged, not queued.
  - Cleared on STEP acceptance, unless a new STEP is raised that same cycle (set wins).
- toggle_pend:
  - click_in while seed_en_in = 0 and toggle_pend = 0 latches cursor_x_in/cursor_y_in and sets toggle_pend.
  - Clicks are ignored while toggle_pend is set (first click wins) and while seed_en_in = 1.
- seed_pend:
  - Triggers: seed_en_in rising edge, or any seed_idx_in change while seed_en_in = 1.
  - A trigger latches seed_idx_in and sets seed_pend. A later trigger while pending overwrites the index (latest wins).
  - A trigger during an active SEED command does not alter the payload; it re-sets seed_pend after acceptance.
- FSM states:
  - IDLE: if any pending flag is set, the next cycle enters ISSUE with cmd_valid_out = 1.
    - Priority: SEED > TOGGLE > STEP.
    - cmd_op_out and payload are registered at entry.
  - ISSUE:
    - cmd_valid_out, cmd_op_out and payload are held stable until cmd_valid_out && cmd_ready_in.
    - On that handshake: clear the matching pending flag (subject to the set-wins rule), return to IDLE, and drive cmd_valid_out = 0 the following cycle.
    - Minimum one idle cycle between commands.
    - cmd_ready_in while not valid is ignored.
  - A higher-priority request arriving during ISSUE does not pre-empt the current command.
- Payload rules:
  - cmd_x_out/cmd_y_out are meaningful only for TOGGLE; cmd_seed_out only for SEED.
  - Unused payload fields hold their last value.
  - cmd_op_out = 00 whenever cmd_valid_out = 0.
- generation_out:
  - +1 (modulo 2^GEN_WIDTH) on STEP acceptance.
  - Cleared to 0 on SEED acceptance.
  - Updates the cycle after the handshake.

Test Plan:
- Reset release, speed_in = 15, cmd_ready_in = 1, four frame_start_in pulses -> four STEP commands, one per frame; generation_out = 4.
- speed_in = 13 (P = 3), ready held high, 9 frames -> STEPs after frames 3, 6, 9 only; speed_in = 0 -> no further STEPs, paused_out = 1.
- cmd_ready_in held low for 3 frames at P = 1 -> one STEP held stable with payload unchanged; after ready, exactly one STEP accepted (coalesced), generation_out +1.
- Cursor (100, 37), click_in pulse -> TOGGLE with cmd_x_out = 100, cmd_y_out = 37. A second click at (5, 5) while pending is ignored. Click with seed_en_in = 1 produces no command.
- seed_idx_in = 2, raise seed_en_in, then change idx to 3 before ready -> single SEED with cmd_seed_out = 2, then a second SEED with 3; generation_out = 0; no STEPs while seed_en_in = 1.
- STEP, TOGGLE and SEED pending simultaneously -> issue order SEED, TOGGLE, STEP, each separated by one idle cycle. Assert rst_n_in low mid-ISSUE -> cmd_valid_out drops immediately, all flags clear.
